// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] RegAddrBus;
    typedef logic [REG_DATA_W-1:0] RegBus;

    localparam RegAddrBus ZERO_REG = '0;

    // True when a non-zero ID source address names the given write destination.
    function automatic logic src_match(input RegAddrBus rs, input RegAddrBus rt, input RegAddrBus w);
        return ((rs != ZERO_REG) && (rs == w)) || ((rt != ZERO_REG) && (rt == w));
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding long-latency results until the regfile port is free.
// Occupancy is tracked with a counter so head==tail is never ambiguous.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [4:0]             push_waddr,
    input  logic [31:0]            push_wdata,
    output logic [PTR_W:0]         cnt,
    output logic [4:0]             head_waddr,
    output logic [31:0]            head_wdata,
    output logic [DEPTH-1:0]       ent_valid,
    output logic [DEPTH-1:0][4:0]  ent_waddr
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [PTR_W:0]        cnt_q, cnt_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0][4:0] waddr_q;
    RegBus                 wdata_q [DEPTH];
    logic                  do_push, do_pop;

    // Ignore requests that would overflow or underflow the queue.
    assign do_push = push && (cnt_q != FULL_CNT);
    assign do_pop  = pop && (cnt_q != '0);

    // Pointer, occupancy and per-entry valid bookkeeping.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (do_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (do_push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state; reset empties the queue immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage; only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if (do_push) begin
            waddr_q[tail_q] <= push_waddr;
            wdata_q[tail_q] <= push_wdata;
        end
    end

    assign cnt        = cnt_q;
    assign head_waddr = waddr_q[head_q];
    assign head_wdata = wdata_q[head_q];
    assign ent_valid  = valid_q;
    assign ent_waddr  = waddr_q;

endmodule

// File: rtl/wb_arbiter.sv
// Owns the single regfile write port: merges in-order pipeline writeback
// with queued long-latency results and flags ID reads of pending registers.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pipe_we,
    input  logic [4:0]     pipe_waddr,
    input  logic [31:0]    pipe_wdata,
    input  logic           lu_valid,
    input  logic [4:0]     lu_waddr,
    input  logic [31:0]    lu_wdata,
    output logic           lu_ready,
    input  logic [4:0]     rs_raddr,
    input  logic [4:0]     rt_raddr,
    output logic           stallreq_for_wb,
    output logic           rf_we,
    output logic [4:0]     rf_waddr,
    output logic [31:0]    rf_wdata,
    output logic [PTR_W:0] fifo_cnt
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic                  pipe_sel, lu_acc, lu_wr, fifo_nonempty;
    logic                  fifo_pop, fifo_push, lu_direct;
    logic [4:0]            head_waddr;
    logic [31:0]           head_wdata;
    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0][4:0] ent_waddr;

    logic                  rf_we_q, rf_we_d;
    RegAddrBus             rf_waddr_q, rf_waddr_d;
    RegBus                 rf_wdata_q, rf_wdata_d;
    logic                  rf_lu_q, rf_lu_d;

    wb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .push_waddr (lu_waddr),
        .push_wdata (lu_wdata),
        .cnt        (fifo_cnt),
        .head_waddr (head_waddr),
        .head_wdata (head_wdata),
        .ent_valid  (ent_valid),
        .ent_waddr  (ent_waddr)
    );

    // Writes to $0 never occupy the port; $0 lu results are accepted and dropped.
    assign pipe_sel      = pipe_we && (pipe_waddr != ZERO_REG);
    assign lu_ready      = !rst && (fifo_cnt < FULL_CNT);
    assign lu_acc        = lu_valid && lu_ready;
    assign lu_wr         = lu_acc && (lu_waddr != ZERO_REG);
    assign fifo_nonempty = (fifo_cnt != '0);

    // Priority: pipeline, then FIFO head, then a fresh lu result bypassing the empty FIFO.
    assign fifo_pop  = !pipe_sel && fifo_nonempty;
    assign lu_direct = !pipe_sel && !fifo_nonempty && lu_wr;
    assign fifo_push = lu_wr && !lu_direct;

    // Select the write for next cycle; address/data hold when the port is idle.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rf_lu_d    = 1'b0;
        if (pipe_sel) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_waddr;
            rf_wdata_d = pipe_wdata;
        end else if (fifo_pop) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head_waddr;
            rf_wdata_d = head_wdata;
            rf_lu_d    = 1'b1;
        end else if (lu_direct) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = lu_waddr;
            rf_wdata_d = lu_wdata;
            rf_lu_d    = 1'b1;
        end
    end

    // Registered regfile write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_lu_q    <= 1'b0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_lu_q    <= rf_lu_d;
        end
    end

    // Stall ID while a source register has a queued or retiring long-latency write.
    always_comb begin
        stallreq_for_wb = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && src_match(rs_raddr, rt_raddr, ent_waddr[i]))
                stallreq_for_wb = 1'b1;
        end
        if (rf_we_q && rf_lu_q && src_match(rs_raddr, rt_raddr, rf_waddr_q))
            stallreq_for_wb = 1'b1;
        if (rst)
            stallreq_for_wb = 1'b0;
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Producer-side counterpart to the ID-stage forwarding logic. Owns the single register-file write port.
- Merges the in-order pipeline writeback (MEM/WB) with results from a long-latency unit (mul/div) that arrive asynchronously to the pipeline.
- Buffers long-latency results in a small FIFO while the port is busy.
- Drives the registered regfile write and tells ID when a source register still has a queued write, so ID can stall.

Parameters:
DEPTH, 4, FIFO entries for long-latency results; power of two, at least 2.
PTR_W, 2, log2(DEPTH); index width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
pipe_we  in  1  pipeline writeback valid this cycle; cannot be back-pressured
pipe_waddr  in  5  pipeline destination register
pipe_wdata  in  32  pipeline result
lu_valid  in  1  long-latency result valid
lu_waddr  in  5  long-latency destination register
lu_wdata  in  32  long-latency result
lu_ready  out  1  arbiter can accept a long-latency result this cycle
rs_raddr  in  5  ID rs read address
rt_raddr  in  5  ID rt read address
stallreq_for_wb  out  1  ID source register matches a queued or in-flight long-latency write
rf_we  out  1  regfile write enable, registered
rf_waddr  out  5  regfile write address, registered
rf_wdata  out  32  regfile write data, registered
fifo_cnt  out  PTR_W+1  current FIFO occupancy, for debug

Behaviour:
- Reset (async, rst=1): rf_we=0, rf_waddr=0, rf_wdata=0, FIFO empty (head=tail=cnt=0), all entry valid bits cleared.
- Reset effects while rst is held:
  - lu_ready=0 and stallreq_for_wb=0 while rst=1.
  - Asserting rst mid-operation discards all queued entries immediately.
- Acceptance:
  - lu_ready = (cnt < DEPTH) combinationally.
  - A result is accepted when lu_valid & lu_ready.
  - lu_valid with lu_ready=0: the producer must hold its data. It is not accepted that cycle.
- Port selection, once per cycle, in strict priority:
  1. pipe_we=1 and pipe_waddr!=0: write the pipeline result.
  2. else, FIFO non-empty: pop the head and write it.
  3. else, an accepted lu result (lu_waddr!=0): write it directly, bypassing the FIFO.
  4. else: no write.
- Enqueue rule: an accepted lu result is pushed to the tail unless rule 3 consumed it.
  - Ordering between long-latency results is preserved: FIFO order is arrival order.
  - A new lu result never overtakes a queued one.
- Simultaneous push and pop: when the FIFO is non-empty, both occur in the same cycle and cnt is unchanged. Full plus pop still gives lu_ready=0, because lu_ready depends only on cnt.
- Writes to $0:
  - Pipeline writes with pipe_waddr==0 are treated as pipe_we=0. They do not occupy the port.
  - Accepted lu results with lu_waddr==0 are consumed and dropped: never enqueued, never written.
- Latency:
  - Selection is registered. rf_we/rf_waddr/rf_wdata reflect the selected write one cycle after selection.
  - The minimum lu-to-regfile latency is 1 cycle.
  - A result stuck behind continuous pipe_we waits indefinitely; there is no starvation guard. A pipeline bubble always drains one entry.
- Wrap-around: head and tail are PTR_W-bit and wrap modulo DEPTH. Full/empty is decided by cnt, not by pointer equality.
- stallreq_for_wb is asserted, combinationally, when rs_raddr or rt_raddr is non-zero and equals either of:
  - any valid FIFO entry's waddr, or
  - rf_waddr while rf_we=1 and that registered write came from the long-latency path.
- Not handled here:
  - Pipeline-sourced writes are covered by the existing bypass network.
  - WAW between a queued lu entry and a younger pipeline write to the same register is prevented upstream: issue stalls on stallreq_for_wb. The arbiter does not reorder.

Decomposition:
- Shared defines header: RegAddrBus [4:0], RegBus [31:0], zero-register constant.
- One sub-module, wb_fifo: parameterised DEPTH, synchronous push/pop, async reset.
  - Exposes cnt, head entry, and per-entry {valid, waddr} for the stall compare.
- Arbitration, output register and stall compare stay in wb_arbiter.

Test Plan:
- Reset mid-queue: fill 3 entries, pulse rst -> fifo_cnt=0, rf_we=0 the same cycle, lu_ready=1 after release.
- Idle port: lu_valid=1, waddr=5, wdata=0xDEADBEEF, pipe_we=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; fifo_cnt stays 0.
- Contention:
  - Stimulus: pipe_we=1 for 6 cycles (waddr=1..6) while lu sends waddr=10,11,12,13,14 on consecutive cycles.
  - Required: pipeline writes appear 1..6 in order; lu_ready=0 on the 5th lu attempt (cnt=4); then 10,11,12,13,14 drain in order after pipe_we drops.
- Stall compare: queue waddr=7 behind pipe_we -> rs_raddr=7 gives stallreq_for_wb=1; rt_raddr=7 also gives 1; raddr=0 gives 0. Drops to 0 the cycle after the rf_we write of reg 7 retires.
- Zero register: pipe_we=1 with waddr=0 and lu_valid with waddr=9 in the same cycle -> lu written directly next cycle. An lu result with waddr=0 -> accepted, never written, cnt unchanged.
- Wrap-around: 3×DEPTH random push/pop cycles -> regfile write stream equals reference-model order; cnt never exceeds DEPTH.
